insn_encoder: RTL
=================

Name: insn_encoder

Overview:
- Inverse of the immediate/field decode path: packs RV32I instruction fields (opcode, registers, functs, immediate) into a 32-bit instruction word.
- Checks each immediate for range and alignment against the encoding format.
- Buffers results in a 2-entry output queue with valid/ready handshakes on both sides.
- Used by the instruction-stream generator and self-checking benches that feed fetch/decode, and as a round-trip checker against decode.

Parameters:
- DWIDTH, 32, instruction/immediate width (only 32 supported).
- CWIDTH, 16, width of the delivered-instruction counter.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous active-high reset
- req_valid_i  input  1  request fields valid
- req_ready_o  output  1  encoder can accept a request this cycle
- opcode_i  input  7  major opcode
- rd_i  input  5  destination register
- rs1_i  input  5  source register 1
- rs2_i  input  5  source register 2
- funct3_i  input  3  funct3
- funct7_i  input  7  funct7 (R-type; upper bits for shift-immediates)
- imm_i  input  DWIDTH  signed byte-offset/immediate value as the programmer intends it
- insn_valid_o  output  1  output word valid
- insn_ready_i  input  1  consumer accepts output
- insn_o  output  DWIDTH  encoded instruction
- err_o  output  1  sideband travelling with insn_o; immediate illegal or opcode unsupported
- count_o  output  CWIDTH  number of instructions delivered (saturating)

Behaviour:
- Clock, reset and transfers:
  - One clock (clk). Reset is synchronous, active-high (reset).
  - Reset values: insn_valid_o=0, insn_o=0, err_o=0, count_o=0, queue empty, req_ready_o=1 from the first cycle after reset.
  - Accept when req_valid_i && req_ready_o at the rising edge. Deliver when insn_valid_o && insn_ready_i.
  - req_ready_o = (occupancy < 2). It depends on registered state only; there is no combinational path from insn_ready_i.
- Latency and ordering:
  - A request accepted at edge N appears on insn_o in cycle N+1 when the queue was empty. FIFO order is preserved.
  - Push and pop in the same cycle: occupancy unchanged. Legal at occupancy 1. At occupancy 2 a push is blocked by ready.
  - insn_o and err_o stay stable while insn_valid_o && !insn_ready_i.
- Encoding (combinational, before the queue):
  - R, 0110011: {funct7, rs2, rs1, funct3, rd, op}.
  - I, 0000011 / 0010011 / 1100111 / 1110011: {imm[11:0], rs1, funct3, rd, op}. Error if imm_i is not in [-2048, 2047].
    - Exception, 0010011 with funct3=001/101: the word is {funct7, imm[4:0], rs1, funct3, rd, op}. Error if imm_i is not in [0, 31].
  - S, 0100011: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}. Range as I.
  - B, 1100011: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}. Error if imm_i is not in [-4096, 4094] or imm_i[0]=1.
  - U, 0110111 / 0010111: {imm[31:12], rd, op}. Error if imm_i[11:0] != 0.
  - J, 1101111: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}. Error if imm_i is not in [-1048576, 1048574] or imm_i[0]=1.
  - On a range or alignment error the word is still encoded from the truncated bits, with err=1.
  - Unsupported opcode: word = NOP 32'h00000013, err=1.
  - Unused fields for a format are ignored.
- Counter: count_o increments on each delivery and saturates at all-ones. Errored words are counted.
- Reset mid-operation: the queue is flushed, pending words are dropped, the counter is cleared, and no partial delivery occurs.

Decomposition:
- Package insn_enc_pkg holds:
  - opcode localparams (OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_REG);
  - enum fmt_e {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD};
  - constant NOP_INSN;
  - per-format immediate min/max constants.
- Sub-module insn_pack: purely combinational fields -> {insn, err}.
- The top level holds the 2-entry queue, the handshakes and the counter.

Test Plan:
- ADDI: opcode 0010011, rd=1, rs1=0, f3=0, imm=-1 -> insn 32'hFFF00093, err 0, valid in cycle after accept.
- SW and LUI: SW rs1=1, rs2=2, f3=010, imm=8 -> 32'h0020A423. LUI rd=5, imm=32'h12345000 -> 32'h123452B7. Both err 0.
- Errors: JAL rd=1, imm=8 -> 32'h008000EF, err 0. BEQ rs1=rs2=0, imm=3 -> 32'h00000163 with err 1. Opcode 7'b1111111 -> 32'h00000013, err 1.
- Backpressure: insn_ready_i=0, offer 3 requests back-to-back -> first two accepted, req_ready_o=0 from the cycle after the 2nd, 3rd held. Raise ready -> words delivered in order, count_o=3.
- Throughput: steady req_valid_i=1, insn_ready_i=1 -> one word per cycle, occupancy stays 1, count_o tracks deliveries.
- Reset with 2 queued words: assert reset 1 cycle -> next cycle insn_valid_o=0, count_o=0, req_ready_o=1, and no stale word ever appears.

Source files
------------

// File: rtl/insn_enc_pkg.sv
// Shared opcodes, format enum, immediate limits and queue entry type for the
// RV32I instruction encoder.
package insn_enc_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;

   localparam int IMM_I_MIN  = -2048;
   localparam int IMM_I_MAX  = 2047;
   localparam int IMM_SH_MIN = 0;
   localparam int IMM_SH_MAX = 31;
   localparam int IMM_B_MIN  = -4096;
   localparam int IMM_B_MAX  = 4094;
   localparam int IMM_J_MIN  = -1048576;
   localparam int IMM_J_MAX  = 1048574;

   typedef enum logic [2:0] {
      FMT_R,
      FMT_I,
      FMT_S,
      FMT_B,
      FMT_U,
      FMT_J,
      FMT_BAD
   } fmt_e;

   typedef struct packed {
      logic            err;
      logic [XLEN-1:0] insn;
   } q_entry_t;

   function automatic fmt_e fmt_of(input logic [6:0] op);
      fmt_e f;
      case (op)
         OP_REG:                               f = FMT_R;
         OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM:  f = FMT_I;
         OP_STORE:                             f = FMT_S;
         OP_BRANCH:                            f = FMT_B;
         OP_LUI, OP_AUIPC:                     f = FMT_U;
         OP_JAL:                               f = FMT_J;
         default:                              f = FMT_BAD;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/insn_pack.sv
// Combinational field packer: RV32I fields plus intended immediate -> word and
// an error flag for out-of-range/misaligned immediates or unknown opcodes.
module insn_pack
   import insn_enc_pkg::*;
(
   input  logic [6:0]      opcode_i,
   input  logic [4:0]      rd_i,
   input  logic [4:0]      rs1_i,
   input  logic [4:0]      rs2_i,
   input  logic [2:0]      funct3_i,
   input  logic [6:0]      funct7_i,
   input  logic [XLEN-1:0] imm_i,
   output logic [XLEN-1:0] insn_c,
   output logic            err_c
);

   logic signed [XLEN-1:0] imm_s;
   fmt_e                   fmt;
   logic                   is_shift;

   assign imm_s    = $signed(imm_i);
   assign fmt      = fmt_of(opcode_i);
   assign is_shift = (opcode_i == OP_IMM) && (funct3_i[1:0] == 2'b01);

   always_comb begin
      insn_c = NOP_INSN;
      err_c  = 1'b0;
      case (fmt)
         FMT_R: begin
            insn_c = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
         end
         FMT_I: begin
            // Shift-immediates carry funct7 in the upper bits and a 5-bit shamt
            if (is_shift) begin
               insn_c = {funct7_i, imm_i[4:0], rs1_i, funct3_i, rd_i, opcode_i};
               err_c  = (imm_s < IMM_SH_MIN) || (imm_s > IMM_SH_MAX);
            end else begin
               insn_c = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
               err_c  = (imm_s < IMM_I_MIN) || (imm_s > IMM_I_MAX);
            end
         end
         FMT_S: begin
            insn_c = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
            err_c  = (imm_s < IMM_I_MIN) || (imm_s > IMM_I_MAX);
         end
         FMT_B: begin
            insn_c = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                      imm_i[4:1], imm_i[11], opcode_i};
            err_c  = (imm_s < IMM_B_MIN) || (imm_s > IMM_B_MAX) || imm_i[0];
         end
         FMT_U: begin
            insn_c = {imm_i[31:12], rd_i, opcode_i};
            err_c  = (imm_i[11:0] != 12'd0);
         end
         FMT_J: begin
            insn_c = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
            err_c  = (imm_s < IMM_J_MIN) || (imm_s > IMM_J_MAX) || imm_i[0];
         end
         default: begin
            insn_c = NOP_INSN;
            err_c  = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/insn_encoder.sv
// RV32I instruction encoder: packs request fields and buffers the encoded word
// in a 2-entry output queue with valid/ready on both sides and a delivery count.
module insn_encoder
   import insn_enc_pkg::*;
#(
   parameter int unsigned DWIDTH = 32,
   parameter int unsigned CWIDTH = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [6:0]        opcode_i,
   input  logic [4:0]        rd_i,
   input  logic [4:0]        rs1_i,
   input  logic [4:0]        rs2_i,
   input  logic [2:0]        funct3_i,
   input  logic [6:0]        funct7_i,
   input  logic [DWIDTH-1:0] imm_i,
   output logic              insn_valid_o,
   input  logic              insn_ready_i,
   output logic [DWIDTH-1:0] insn_o,
   output logic              err_o,
   output logic [CWIDTH-1:0] count_o
);

   q_entry_t          head_q, head_d;
   q_entry_t          tail_q, tail_d;
   logic [1:0]        occ_q, occ_d;
   logic              valid_q, valid_d;
   logic              ready_q, ready_d;
   logic [CWIDTH-1:0] count_q, count_d;

   q_entry_t          new_entry;
   logic              push, pop;

   insn_pack u_pack (
      .opcode_i (opcode_i),
      .rd_i     (rd_i),
      .rs1_i    (rs1_i),
      .rs2_i    (rs2_i),
      .funct3_i (funct3_i),
      .funct7_i (funct7_i),
      .imm_i    (imm_i),
      .insn_c   (new_entry.insn),
      .err_c    (new_entry.err)
   );

   // ready/valid are flops mirroring occupancy, so no path from insn_ready_i
   assign push = req_valid_i && ready_q;
   assign pop  = valid_q && insn_ready_i;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      occ_d   = occ_q;
      count_d = count_q;
      case ({push, pop})
         2'b11: begin
            // Only reachable at occupancy 1: the new word replaces the head
            head_d = new_entry;
         end
         2'b10: begin
            if (occ_q == 2'd0) head_d = new_entry;
            else               tail_d = new_entry;
            occ_d = occ_q + 2'd1;
         end
         2'b01: begin
            head_d = tail_q;
            occ_d  = occ_q - 2'd1;
         end
         default: ;
      endcase
      if (pop && (count_q != {CWIDTH{1'b1}})) count_d = count_q + CWIDTH'(1);
      valid_d = (occ_d != 2'd0);
      ready_d = (occ_d != 2'd2);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         occ_q   <= 2'd0;
         valid_q <= 1'b0;
         ready_q <= 1'b1;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         occ_q   <= occ_d;
         valid_q <= valid_d;
         ready_q <= ready_d;
         count_q <= count_d;
      end
   end

   assign req_ready_o  = ready_q;
   assign insn_valid_o = valid_q;
   assign insn_o       = DWIDTH'(head_q.insn);
   assign err_o        = head_q.err;
   assign count_o      = count_q;

endmodule
